// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, imem addressing, registered output with valid/ready.
// Optional FETCH_TRAP_EN adds alignment/range checks with a sticky fault.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fault
);

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [32:0] BYTE_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redir_target;
    logic        redir_bad;
    logic        pc_oob;
    logic        load;
    logic        take_redir;
    logic        trap;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

`ifdef FETCH_TRAP_EN
    assign redir_bad    = (redirect_pc[1:0] != 2'b00) ||
                          ({1'b0, redirect_pc} >= BYTE_LIMIT);
    assign pc_oob       = ({1'b0, pc} >= BYTE_LIMIT);
    assign redir_target = redirect_pc;
`else
    logic unused_cfg;
    assign unused_cfg   = ^{1'b0, redirect_pc[1:0], BYTE_LIMIT};
    assign redir_bad    = 1'b0;
    assign pc_oob       = 1'b0;
    assign redir_target = {redirect_pc[31:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks halt and load; BOOT ignores everything.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        take_redir = 1'b0;
        trap       = 1'b0;
        unique case (state)
            BOOT: state_next = RUN;
            RUN, HALTED: begin
                if (redirect_valid) begin
                    if (redir_bad) begin
                        trap       = 1'b1;
                        state_next = HALTED;
                    end else begin
                        take_redir = 1'b1;
                        state_next = RUN;
                    end
                end else if (state == RUN) begin
                    if (halt) begin
                        state_next = HALTED;
                    end else if (!out_valid || out_ready) begin
                        if (pc_oob) begin
                            trap       = 1'b1;
                            state_next = HALTED;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            out_valid    <= 1'b0;
            out_instr    <= NOP;
            out_pc       <= 32'd0;
            out_pc_plus4 <= 32'd4;
            fault        <= 1'b0;
        end else if (take_redir) begin
            pc        <= redir_target;
            out_valid <= 1'b0;
        end else if (trap) begin
            fault     <= 1'b1;
            out_valid <= 1'b0;
        end else if (load) begin
            out_instr    <= imem_instr;
            out_pc       <= pc;
            out_pc_plus4 <= pc_plus4;
            out_valid    <= 1'b1;
            pc           <= pc_plus4;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
